// File: rtl/bit_serializer.sv
// WIDTH-bit to 1-bit selector/serializer: registered random bit select (mode=0)
// or MSB-first word streaming with valid/ready backpressure (mode=1).
module bit_serializer #(
  parameter int WIDTH = 64,
  parameter int SEL_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic [WIDTH-1:0] data_in,
  input  logic [SEL_W-1:0] sel,
  input  logic             sel_valid,
  input  logic             load,
  output logic             load_ready,
  output logic             bit_out,
  output logic             bit_valid,
  input  logic             bit_ready,
  output logic             busy,
  output logic             last
);

  localparam int IW = $clog2(WIDTH);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             bit_out_q, bit_out_d;
  logic             bit_valid_q, bit_valid_d;
  logic             last_q, last_d;

  logic [IW-1:0]    ridx;
  logic             sel_in_range;
  logic             do_load;

  // Loading is allowed from IDLE in stream mode, or on the final accept of a
  // word so the next word follows with no bubble.
  assign load_ready   = ((state_q == IDLE) && mode) ||
                        ((state_q == SHIFT) && last_q && bit_ready);
  assign do_load      = load && load_ready;
  assign sel_in_range = (sel < SEL_W'(WIDTH));
  assign ridx         = IW'(WIDTH - 1) - sel[IW-1:0];

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    idx_d       = idx_q;
    bit_out_d   = bit_out_q;
    bit_valid_d = bit_valid_q;
    last_d      = last_q;

    if (state_q == IDLE) begin
      last_d = 1'b0;
      if (!mode) begin
        bit_valid_d = sel_valid;
        if (sel_valid)
          bit_out_d = sel_in_range ? data_in[ridx] : 1'b0;
      end else begin
        bit_valid_d = 1'b0;
      end
    end else if (bit_ready) begin
      if (last_q) begin
        state_d     = IDLE;
        shreg_d     = '0;
        idx_d       = '0;
        bit_out_d   = 1'b0;
        bit_valid_d = 1'b0;
        last_d      = 1'b0;
      end else begin
        shreg_d   = shreg_q << 1;
        idx_d     = idx_q + 1'b1;
        bit_out_d = shreg_q[WIDTH-2];
        last_d    = (idx_q == IW'(WIDTH - 2));
      end
    end

    if (do_load) begin
      state_d     = SHIFT;
      shreg_d     = data_in;
      idx_d       = '0;
      bit_out_d   = data_in[WIDTH-1];
      bit_valid_d = 1'b1;
      last_d      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      idx_q       <= '0;
      bit_out_q   <= 1'b0;
      bit_valid_q <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      idx_q       <= idx_d;
      bit_out_q   <= bit_out_d;
      bit_valid_q <= bit_valid_d;
      last_q      <= last_d;
    end
  end

  assign bit_out   = bit_out_q;
  assign bit_valid = bit_valid_q;
  assign last      = last_q;
  assign busy      = (state_q == SHIFT);

endmodule

// File: tb/tb_bit_serializer.sv
// Randomized bench for bit_serializer: random select mode, streaming with
// backpressure, back-to-back words and reset mid-stream against a word/index model.
module tb_bit_serializer;
  localparam int WIDTH = 64;
  localparam int SEL_W = 7;

  logic             clk = 1'b0;
  logic             rst;
  logic             mode;
  logic [WIDTH-1:0] data_in;
  logic [SEL_W-1:0] sel;
  logic             sel_valid;
  logic             load;
  logic             load_ready;
  logic             bit_out;
  logic             bit_valid;
  logic             bit_ready;
  logic             busy;
  logic             last;

  int n_checks = 0;
  int n_fail   = 0;

  bit_serializer #(.WIDTH(WIDTH), .SEL_W(SEL_W)) dut (
    .clk(clk), .rst(rst), .mode(mode), .data_in(data_in), .sel(sel),
    .sel_valid(sel_valid), .load(load), .load_ready(load_ready),
    .bit_out(bit_out), .bit_valid(bit_valid), .bit_ready(bit_ready),
    .busy(busy), .last(last)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  task automatic test_reset();
    rst = 1'b1; mode = 1'b1; data_in = '0; sel = '0; sel_valid = 1'b0;
    load = 1'b0; bit_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    n_checks++;
    if ({bit_valid, busy, bit_out, last, load_ready} !== 5'b00001) begin
      n_fail++;
      $display("FAIL reset: got v/busy/bit/last/lr=%b required 00001",
               {bit_valid, busy, bit_out, last, load_ready});
    end
    rst = 1'b0;
  endtask

  task automatic test_random();
    logic [6:0]  dsel [4] = '{7'd0, 7'd63, 7'd1, 7'd100};
    logic [63:0] d;
    int          s;
    logic        exp_v, exp_b;
    exp_v = 1'b0; exp_b = 1'b0;
    mode = 1'b0;
    @(negedge clk);
    for (int i = 0; i <= 64; i++) begin
      if (i > 0) begin
        #1;
        n_checks++;
        if (bit_valid !== exp_v || (exp_v && bit_out !== exp_b)) begin
          n_fail++;
          $display("FAIL random_%0d: got v=%b bit=%b required v=%b bit=%b",
                   i - 1, bit_valid, bit_out, exp_v, exp_b);
        end
      end
      if (i < 4) begin
        d = 64'h8000_0000_0000_0001; s = int'(dsel[i]); sel_valid = 1'b1;
      end else if (i < 64) begin
        d = {$urandom, $urandom}; s = $urandom_range(0, 127);
        sel_valid = ($urandom_range(0, 3) != 0);
      end else begin
        d = '0; s = 0; sel_valid = 1'b0;
      end
      data_in = d; sel = 7'(s);
      exp_v = sel_valid;
      exp_b = (s < WIDTH) ? d[WIDTH-1-s] : 1'b0;
      @(negedge clk);
    end
    // sel_valid has no effect once stream mode is selected
    mode = 1'b1; sel_valid = 1'b1; load = 1'b0;
    @(negedge clk); #1;
    n_checks++;
    if (bit_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL random_ignored_in_stream: got v=%b required 0", bit_valid);
    end
    sel_valid = 1'b0;
  endtask

  task automatic test_stream();
    logic [63:0] w = 64'hA500_0000_0000_00FF;
    logic [7:0]  head = 8'b1010_0101;
    logic        exp_b;
    mode = 1'b1; bit_ready = 1'b1;
    @(negedge clk);
    data_in = w; load = 1'b1; #1;
    n_checks++;
    if (load_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL stream_load_ready: got %b required 1", load_ready);
    end
    @(negedge clk);
    load = 1'b0; data_in = {$urandom, $urandom};
    for (int i = 0; i < 64; i++) begin
      exp_b = (i < 8) ? head[7-i] : (i >= 56);
      #1;
      n_checks++;
      if ({bit_valid, bit_out, last, busy} !== {1'b1, exp_b, (i == 63), 1'b1}) begin
        n_fail++;
        $display("FAIL stream_bit%0d: got v/bit/last/busy=%b required %b", i,
                 {bit_valid, bit_out, last, busy}, {1'b1, exp_b, (i == 63), 1'b1});
      end
      if (i == 63) begin
        n_checks++;
        if (load_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL stream_final_load_ready: got %b required 1", load_ready);
        end
      end
      @(negedge clk);
    end
    #1;
    n_checks++;
    if ({bit_valid, busy, last} !== 3'b000) begin
      n_fail++;
      $display("FAIL stream_end_idle: got v/busy/last=%b required 000", {bit_valid, busy, last});
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] w;
    int n, stall, cyc;
    logic rdy;
    for (int run = 0; run < 2; run++) begin
      w = {$urandom, $urandom};
      mode = 1'b1; bit_ready = 1'b0;
      @(negedge clk);
      data_in = w; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      n = 0; stall = 0; cyc = 0;
      while (n < 64 && cyc < 1000) begin
        if (run == 0) begin
          rdy = !(n == 6 && stall < 3);
          if (!rdy) stall++;
        end else begin
          rdy = 1'($urandom_range(0, 1));
          load = (n != 63) && ($urandom_range(0, 1) == 1);
          mode = 1'($urandom_range(0, 1));
          sel_valid = 1'($urandom_range(0, 1));
        end
        data_in = {$urandom, $urandom};
        bit_ready = rdy;
        #1;
        n_checks++;
        if ({bit_valid, bit_out, last, busy} !== {1'b1, w[63-n], (n == 63), 1'b1}) begin
          n_fail++;
          $display("FAIL bp%0d_bit%0d: got v/bit/last/busy=%b required %b", run, n,
                   {bit_valid, bit_out, last, busy}, {1'b1, w[63-n], (n == 63), 1'b1});
        end
        n_checks++;
        if (load_ready !== ((n == 63) && rdy)) begin
          n_fail++;
          $display("FAIL bp%0d_load_ready%0d: got %b required %b", run, n,
                   load_ready, ((n == 63) && rdy));
        end
        if (rdy) n++;
        cyc++;
        @(negedge clk);
      end
      n_checks++;
      if (cyc >= 1000) begin
        n_fail++;
        $display("FAIL bp%0d_timeout: got %0d bits required 64", run, n);
      end
      load = 1'b0; mode = 1'b1; sel_valid = 1'b0; bit_ready = 1'b0;
      #1;
      n_checks++;
      if ({bit_valid, busy} !== 2'b00) begin
        n_fail++;
        $display("FAIL bp%0d_end_idle: got v/busy=%b required 00", run, {bit_valid, busy});
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] words [3];
    for (int k = 0; k < 3; k++) words[k] = {$urandom, $urandom};
    mode = 1'b1; bit_ready = 1'b1;
    @(negedge clk);
    data_in = words[0]; load = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 64; i++) begin
        if (i == 63 && k < 2) begin
          load = 1'b1; data_in = words[k+1];
        end else begin
          load = 1'b0; data_in = {$urandom, $urandom};
        end
        #1;
        n_checks++;
        if ({bit_valid, bit_out, last, busy} !== {1'b1, words[k][63-i], (i == 63), 1'b1}) begin
          n_fail++;
          $display("FAIL b2b_w%0d_bit%0d: got v/bit/last/busy=%b required %b", k, i,
                   {bit_valid, bit_out, last, busy}, {1'b1, words[k][63-i], (i == 63), 1'b1});
        end
        @(negedge clk);
      end
    end
    load = 1'b0; #1;
    n_checks++;
    if ({bit_valid, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL b2b_end_idle: got v/busy=%b required 00", {bit_valid, busy});
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] w1, w2;
    w1 = {$urandom, $urandom}; w2 = {$urandom, $urandom};
    mode = 1'b1; bit_ready = 1'b1;
    @(negedge clk);
    data_in = w1; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      n_checks++;
      if ({bit_valid, bit_out} !== {1'b1, w1[63-i]}) begin
        n_fail++;
        $display("FAIL rstmid_pre_bit%0d: got v/bit=%b required %b", i,
                 {bit_valid, bit_out}, {1'b1, w1[63-i]});
      end
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk); #1;
    n_checks++;
    if ({bit_valid, busy, last, bit_out} !== 4'b0000) begin
      n_fail++;
      $display("FAIL rstmid_idle: got v/busy/last/bit=%b required 0000",
               {bit_valid, busy, last, bit_out});
    end
    rst = 1'b0; data_in = w2; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    for (int i = 0; i < 64; i++) begin
      #1;
      n_checks++;
      if ({bit_valid, bit_out, last} !== {1'b1, w2[63-i], (i == 63)}) begin
        n_fail++;
        $display("FAIL rstmid_new_bit%0d: got v/bit/last=%b required %b", i,
                 {bit_valid, bit_out, last}, {1'b1, w2[63-i], (i == 63)});
      end
      @(negedge clk);
    end
    #1;
    n_checks++;
    if ({bit_valid, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL rstmid_end_idle: got v/busy=%b required 00", {bit_valid, busy});
    end
  endtask

  initial begin
    test_reset();
    test_random();
    test_stream();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
